reg_writeback_unit: RTL
=======================

# reg_writeback_unit

Write-side initiator for the register file's single synchronous write port. Arbitrates writeback requests from the ALU and the load/store unit over valid/ready handshakes and buffers them in a small FIFO. Drains one entry per cycle into the register file and tracks in-flight destinations in a pending scoreboard for the issue stage. Sits between the execute/memory stages and the register file; optionally forwards buffered data to the two register-file read ports.

## Interface
- DATA_WIDTH, 32, register data width
- NUM_REGS, 16, architectural register count
- SEL_WIDTH, 4, register select width (log2 NUM_REGS)
- FIFO_DEPTH, 4, writeback buffer entries (power of two, ≥2)

- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- alu_valid / alu_ready  in / out  1  ALU producer handshake
- alu_sel  in  SEL_WIDTH  ALU destination register
- alu_data  in  DATA_WIDTH  ALU result
- mem_valid / mem_ready  in / out  1  load-unit producer handshake
- mem_sel  in  SEL_WIDTH  load destination register
- mem_data  in  DATA_WIDTH  load result
- wb_hold  in  1  inhibits draining this cycle (port borrowed or debug freeze)
- issue_en  in  1  issue stage marks a destination in flight
- issue_sel  in  SEL_WIDTH  destination being issued
- pending  out  NUM_REGS  per-register in-flight flag
- rf_write_en / rf_write_sel / rf_write_data  out  1 / SEL_WIDTH / DATA_WIDTH  register-file write port
- read_sel  in  2×SEL_WIDTH  register-file read selects to snoop
- fwd_hit  out  2  per read port: buffered write matches
- fwd_data  out  2×DATA_WIDTH  per read port: forwarded value

## Operation
- FIFO entries: {sel, data}. Count 0..FIFO_DEPTH; circular head/tail pointers wrap modulo FIFO_DEPTH.
- Arbitration: at most one acceptance per cycle. Both readies = (count < FIFO_DEPTH) gated by the grant. Only one valid: that source is granted. Both valid: a 1-bit round-robin pointer picks the source. The pointer flips to the other source after each contested grant. Reset value of the pointer favours ALU.
- Non-granted ready = 0 that cycle. Producer holds sel/data stable while valid && !ready.
- Acceptance of sel = 0 completes the handshake but enqueues nothing and changes no state other than the round-robin pointer.
- Drain: rf_write_en = (count != 0) && !wb_hold. rf_write_sel/data = head entry, driven combinationally. The head pops on the same edge.
- Simultaneous enqueue and drain: count unchanged, both pointers advance. When full, no acceptance even if draining that cycle.
- Scoreboard: issue_en && issue_sel != 0 sets pending[issue_sel]. A drain clears pending[rf_write_sel]. Set and clear of the same register in one cycle: set wins. pending[0] is constant 0.
- Issue stage must not issue to a register whose pending bit is set. A bench assertion flags violations; there is no hardware recovery.

## Timing
- Request accepted in cycle N: entry visible at head in N+1; rf_write_en high in N+1 if empty before and not held; register file updated at end of N+1; pending cleared at end of N+1.
- Throughput: 1 write per cycle sustained.
- rst: count 0, pointers 0, pending all 0, round-robin pointer favours ALU. While rst is high, all readies = 0, rf_write_en = 0 and fwd_hit = 0.
- Reset mid-operation discards all buffered entries without writing them.
- alu_ready and mem_ready depend combinationally on the valids (grant). pending and count are registered.

## Configuration
- REG_WRITEBACK_FORWARD_EN defined: fwd_hit[i] is set when any valid FIFO entry has sel == read_sel[i] != 0. fwd_data[i] is the youngest matching entry (closest to tail). This covers the head being written this cycle, since the register file write is not yet visible to its asynchronous reads.
- Undefined: fwd_hit = 0 and fwd_data = 0; no compare logic.

## Test plan
- Reset, then alu_valid with sel=3, data=0xDEADBEEF for one cycle -> alu_ready=1; next cycle rf_write_en=1, sel=3, data=0xDEADBEEF; pending[3] clears after that edge, having been set by issue_en.
- Both valid for 4 cycles with wb_hold=1 (ALU sel 1..2, mem sel 5..6) -> grants alternate ALU, mem, ALU, mem. Fifth cycle: both readies 0 (full). Release hold -> drains in order 1,5,2,6, one per cycle.
- mem_valid, sel=0, data=0x1234 -> mem_ready=1, count stays 0, rf_write_en never asserts.
- Same cycle: issue_en, sel=7 and drain of sel=7 -> pending[7]=1 afterwards.
- With REG_WRITEBACK_FORWARD_EN, hold and enqueue sel=4 data=0x11 then sel=4 data=0x22; read_sel[0]=4 -> fwd_hit[0]=1, fwd_data[0]=0x22. Without the macro -> fwd_hit=0.
- Assert rst with 3 entries buffered -> next cycle count 0, no writes issued, pending all 0.

Source files
------------

// File: rtl/reg_writeback_unit.sv
// Writeback initiator: arbitrates ALU/load results into a FIFO, drains one entry per cycle
// to the register file and tracks in-flight destinations. Optional forwarding: REG_WRITEBACK_FORWARD_EN.
module reg_writeback_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned SEL_WIDTH  = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [SEL_WIDTH-1:0]      alu_sel,
  input  logic [DATA_WIDTH-1:0]     alu_data,
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic [SEL_WIDTH-1:0]      mem_sel,
  input  logic [DATA_WIDTH-1:0]     mem_data,
  input  logic                      wb_hold,
  input  logic                      issue_en,
  input  logic [SEL_WIDTH-1:0]      issue_sel,
  output logic [NUM_REGS-1:0]       pending,
  output logic                      rf_write_en,
  output logic [SEL_WIDTH-1:0]      rf_write_sel,
  output logic [DATA_WIDTH-1:0]     rf_write_data,
  input  logic [2*SEL_WIDTH-1:0]    read_sel,
  output logic [1:0]                fwd_hit,
  output logic [2*DATA_WIDTH-1:0]   fwd_data
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [SEL_WIDTH-1:0]  sel_mem  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;
  logic                  rr_mem;
  logic [NUM_REGS-1:0]   pending_q;
  logic [NUM_REGS-1:0]   pending_next;

  logic                  has_space;
  logic                  contested;
  logic                  grant_alu;
  logic                  grant_mem;
  logic [SEL_WIDTH-1:0]  acc_sel;
  logic [DATA_WIDTH-1:0] acc_data;
  logic                  enq;
  logic                  deq;

  // Arbitration: single acceptance per cycle, round-robin only when both sources request
  always_comb begin
    has_space = !rst && (count < CNT_W'(FIFO_DEPTH));
    contested = alu_valid && mem_valid;
    grant_alu = has_space && alu_valid && (!mem_valid || !rr_mem);
    grant_mem = has_space && mem_valid && (!alu_valid || rr_mem);
    acc_sel   = grant_mem ? mem_sel  : alu_sel;
    acc_data  = grant_mem ? mem_data : alu_data;
    enq       = (grant_alu || grant_mem) && (acc_sel != '0);
    deq       = !rst && (count != '0) && !wb_hold;
  end

  assign alu_ready     = grant_alu;
  assign mem_ready     = grant_mem;
  assign rf_write_en   = deq;
  assign rf_write_sel  = sel_mem[head];
  assign rf_write_data = data_mem[head];
  assign pending       = pending_q;

  // Scoreboard: a new issue overrides a drain of the same register
  always_comb begin
    pending_next = pending_q;
    if (deq) pending_next[rf_write_sel] = 1'b0;
    if (issue_en && (issue_sel != '0)) pending_next[issue_sel] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      rr_mem    <= 1'b0;
      pending_q <= '0;
    end else begin
      if (enq) tail <= tail + PTR_W'(1);
      if (deq) head <= head + PTR_W'(1);
      count     <= count + CNT_W'(enq) - CNT_W'(deq);
      if (contested && has_space) rr_mem <= !rr_mem;
      pending_q <= pending_next;
    end
  end

  // Entry storage needs no reset; occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (enq) begin
      sel_mem[tail]  <= acc_sel;
      data_mem[tail] <= acc_data;
    end
  end

`ifdef REG_WRITEBACK_FORWARD_EN
  logic [PTR_W-1:0]     fwd_idx;
  logic [SEL_WIDTH-1:0] fwd_sel;

  // Scan oldest to youngest so the youngest match wins
  always_comb begin
    fwd_hit  = '0;
    fwd_data = '0;
    fwd_idx  = '0;
    fwd_sel  = '0;
    for (int p = 0; p < 2; p++) begin
      fwd_sel = read_sel[p*SEL_WIDTH +: SEL_WIDTH];
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        fwd_idx = head + PTR_W'(k);
        if (!rst && (CNT_W'(k) < count) && (fwd_sel != '0) && (sel_mem[fwd_idx] == fwd_sel)) begin
          fwd_hit[p] = 1'b1;
          fwd_data[p*DATA_WIDTH +: DATA_WIDTH] = data_mem[fwd_idx];
        end
      end
    end
  end
`else
  logic unused_read_sel;

  assign unused_read_sel = ^read_sel;
  assign fwd_hit  = '0;
  assign fwd_data = '0;
`endif

endmodule
